// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - fetch, data and memory port bundle for mem_port_arbiter
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_ready;

  logic              d_req;
  logic              d_we;
  logic [2:0]        d_size;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [DATA_W-1:0] d_rdata;
  logic              d_ready;

  logic              mem_req;
  logic              mem_we;
  logic [2:0]        mem_size;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;

  logic              bus_err;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_size, d_addr, d_wdata, mem_rdata, mem_ack,
    output if_rdata, if_ready, d_rdata, d_ready,
    output mem_req, mem_we, mem_size, mem_addr, mem_wdata, bus_err
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_size, d_addr, d_wdata, mem_rdata, mem_ack,
    input  if_rdata, if_ready, d_rdata, d_ready,
    input  mem_req, mem_we, mem_size, mem_addr, mem_wdata, bus_err
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one memory port between fetch and data requesters
// ARB_RR_EN: round-robin tie break in IDLE instead of fixed data priority.
module mem_port_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 16
) (
  input logic               clk,
  input logic               reset,
  mem_port_arbiter_if.slave bus
);
  localparam int CNT_W      = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam int CNT_LAST_I = (TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_LAST_I);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  typedef enum logic [1:0] {IDLE, BUSY_D, BUSY_I} state_t;

  state_t            state_q, state_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [2:0]        mem_size_q, mem_size_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic              if_ready_q, if_ready_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic              d_ready_q, d_ready_d;
  logic              bus_err_q, bus_err_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic if_elig, d_elig, pick_d, timeout_hit;

  // A requester still holds req during its own ready cycle; mask it there.
  assign if_elig     = bus.if_req & ~if_ready_q;
  assign d_elig      = bus.d_req & ~d_ready_q;
  assign timeout_hit = (TIMEOUT_CYC != 0) && (cnt_q == CNT_LAST);

`ifdef ARB_RR_EN
  logic last_grant_q, last_grant_d;  // 1 = data, 0 = fetch
  assign pick_d = d_elig & (~if_elig | ~last_grant_q);
`else
  assign pick_d = d_elig;
`endif

  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_size_d  = mem_size_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    if_ready_d  = 1'b0;
    d_ready_d   = 1'b0;
    bus_err_d   = 1'b0;
    cnt_d       = cnt_q;
`ifdef ARB_RR_EN
    last_grant_d = last_grant_q;
`endif
    case (state_q)
      IDLE: begin
        if (pick_d) begin
          state_d     = BUSY_D;
          mem_req_d   = 1'b1;
          mem_we_d    = bus.d_we;
          mem_size_d  = bus.d_size;
          mem_addr_d  = bus.d_addr;
          mem_wdata_d = bus.d_wdata;
          cnt_d       = '0;
`ifdef ARB_RR_EN
          last_grant_d = 1'b1;
`endif
        end else if (if_elig) begin
          state_d     = BUSY_I;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b0;
          mem_size_d  = 3'b010;
          mem_addr_d  = bus.if_addr;
          mem_wdata_d = '0;
          cnt_d       = '0;
`ifdef ARB_RR_EN
          last_grant_d = 1'b0;
`endif
        end
      end
      BUSY_D, BUSY_I: begin
        if (bus.mem_ack) begin
          state_d   = IDLE;
          mem_req_d = 1'b0;
          if (state_q == BUSY_D) begin
            d_ready_d = 1'b1;
            d_rdata_d = mem_we_q ? '0 : bus.mem_rdata;
          end else begin
            if_ready_d = 1'b1;
            if_rdata_d = bus.mem_rdata;
          end
        end else if (timeout_hit) begin
          state_d   = IDLE;
          mem_req_d = 1'b0;
          bus_err_d = 1'b1;
          if (state_q == BUSY_D) begin
            d_ready_d = 1'b1;
            d_rdata_d = '0;
          end else begin
            if_ready_d = 1'b1;
            if_rdata_d = '0;
          end
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d   = IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_size_q  <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      if_ready_q  <= 1'b0;
      d_rdata_q   <= '0;
      d_ready_q   <= 1'b0;
      bus_err_q   <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_size_q  <= mem_size_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rdata_q  <= if_rdata_d;
      if_ready_q  <= if_ready_d;
      d_rdata_q   <= d_rdata_d;
      d_ready_q   <= d_ready_d;
      bus_err_q   <= bus_err_d;
      cnt_q       <= cnt_d;
    end
  end

`ifdef ARB_RR_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant_q <= 1'b0;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end
`endif

  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_size  = mem_size_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.if_ready  = if_ready_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.d_ready   = d_ready_q;
  assign bus.bus_err   = bus_err_q;
endmodule
